// File: rtl/filt_sched.sv
// filt_sched: time-shared 3-sample debounce filter over NCH channels.
// A single next-state engine visits one channel per enabled cycle and
// round-robins through all of them. Each channel's filtered level y[c]
// rises after three consecutive 1 samples and falls after three
// consecutive 0 samples.
// Optional level-change event path (pending/lvl, round-robin arbiter,
// valid/ready output register, sticky overflow) is compiled in only
// when FILT_SCHED_EVT_EN is defined. Otherwise the evt_* and ovf outputs
// are tied low.
module filt_sched #(
   parameter  int unsigned NCH = 4,
   localparam int unsigned CW  = $clog2(NCH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [NCH-1:0] i,
   output logic [NCH-1:0] y,
   output logic [CW-1:0]  slot,
   output logic           evt_valid,
   input  logic           evt_ready,
   output logic [CW-1:0]  evt_ch,
   output logic           evt_lvl,
   output logic           ovf,
   input  logic           ovf_clr
);

   // Per-channel filter state. The Z states count 1s while y is low.
   // The E states count 0s while y is high.
   typedef enum logic [2:0] {
      ST_Z0 = 3'd0,
      ST_Z1 = 3'd1,
      ST_Z2 = 3'd2,
      ST_E0 = 3'd3,
      ST_E1 = 3'd4,
      ST_E2 = 3'd5
   } state_t;

   state_t     st [NCH];
   state_t     cur_st;
   state_t     nxt_st;
   logic       smp;
   logic       y_cur;
   logic       y_new;

   // Shared filter next-state engine.
   function automatic state_t filt_next(input state_t cur, input logic s);
      state_t nxt;
      nxt = ST_Z0;
      case (cur)
         ST_Z0:   nxt = s ? ST_Z1 : ST_Z0;
         ST_Z1:   nxt = s ? ST_Z2 : ST_Z0;
         ST_Z2:   nxt = s ? ST_E0 : ST_Z0;
         ST_E0:   nxt = s ? ST_E0 : ST_E1;
         ST_E1:   nxt = s ? ST_E0 : ST_E2;
         ST_E2:   nxt = s ? ST_E0 : ST_Z0;
         default: nxt = ST_Z0;
      endcase
      return nxt;
   endfunction

   // Evaluate the channel under the slot pointer and derive its new level.
   always_comb begin
      cur_st = st[slot];
      smp    = i[slot];
      nxt_st = filt_next(cur_st, smp);
      y_cur  = y[slot];
      y_new  = y_cur;
      if (nxt_st == ST_E0) begin
         y_new = 1'b1;
      end else if (nxt_st == ST_Z0) begin
         y_new = 1'b0;
      end
   end

   // Channel state, filtered level and slot pointer; all hold while en is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned c = 0; c < NCH; c++) begin
            st[c] <= ST_Z0;
         end
         y    <= '0;
         slot <= '0;
      end else if (en) begin
         st[slot] <= nxt_st;
         y[slot]  <= y_new;
         slot     <= slot + CW'(1);
      end
   end

`ifdef FILT_SCHED_EVT_EN

   logic [NCH-1:0] pending;
   logic [NCH-1:0] lvl;
   logic [CW-1:0]  rr;
   logic [CW-1:0]  gnt;
   logic [CW-1:0]  idx;
   logic           gnt_ok;
   logic           ld;
   logic           y_chg;
   logic           ovf_set;

   // Round-robin search for a pending channel, starting just above the last grant.
   always_comb begin
      gnt    = '0;
      gnt_ok = 1'b0;
      idx    = '0;
      for (int unsigned k = 1; k <= NCH; k++) begin
         idx = rr + CW'(k);
         if (!gnt_ok && pending[idx]) begin
            gnt_ok = 1'b1;
            gnt    = idx;
         end
      end
   end

   // Load and overflow qualifiers. A change on the channel being loaded
   // on the same edge re-arms pending and does not count as an overflow.
   always_comb begin
      ld      = gnt_ok && (!evt_valid || evt_ready);
      y_chg   = en && (y_new != y_cur);
      ovf_set = y_chg && pending[slot] && !(ld && (gnt == slot));
   end

   // Pending/level capture, output register and sticky overflow.
   // A later pending set takes priority over a same-edge grant clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending   <= '0;
         lvl       <= '0;
         rr        <= CW'(NCH - 1);
         evt_valid <= 1'b0;
         evt_ch    <= '0;
         evt_lvl   <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         if (ld) begin
            evt_valid    <= 1'b1;
            evt_ch       <= gnt;
            evt_lvl      <= lvl[gnt];
            pending[gnt] <= 1'b0;
            rr           <= gnt;
         end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
         end
         if (y_chg) begin
            pending[slot] <= 1'b1;
            lvl[slot]     <= y_new;
         end
         if (ovf_set) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end
      end
   end

`else

   logic unused_evt_inputs;

   // Event path absent: outputs tied low and handshake inputs ignored.
   assign evt_valid         = 1'b0;
   assign evt_ch            = '0;
   assign evt_lvl           = 1'b0;
   assign ovf               = 1'b0;
   assign unused_evt_inputs = ^{evt_ready, ovf_clr};

`endif

endmodule

// File: tb/tb_filt_sched.sv
// Directed bench for filt_sched (NCH=4). A behavioural model tracks each
// channel as "level plus run of opposite samples" and tracks the events
// as a pending/level table with a round-robin grant. A compare process
// checks every output on each falling edge. Literal checks pin the model
// at hand-computed edges.
module tb_filt_sched;

   localparam int NCH = 4;
   localparam int CW  = 2;
`ifdef FILT_SCHED_EVT_EN
   localparam bit EVT = 1'b1;
`else
   localparam bit EVT = 1'b0;
`endif

   logic           clk;
   logic           rst;
   logic           en;
   logic [NCH-1:0] i;
   logic [NCH-1:0] y;
   logic [CW-1:0]  slot;
   logic           evt_valid;
   logic           evt_ready;
   logic [CW-1:0]  evt_ch;
   logic           evt_lvl;
   logic           ovf;
   logic           ovf_clr;

   int n_chk  = 0;
   int n_fail = 0;
   bit cmp_on = 1'b0;

   filt_sched #(.NCH(NCH)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .i         (i),
      .y         (y),
      .slot      (slot),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_ch    (evt_ch),
      .evt_lvl   (evt_lvl),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Behavioural model state
   bit [NCH-1:0] m_y;
   int           m_run [NCH];
   int           m_slot;
   bit [NCH-1:0] m_pend;
   bit [NCH-1:0] m_lvl;
   int           m_rr;
   bit           m_ev;
   int           m_ch;
   bit           m_el;
   bit           m_ovf;

   // Model: a level flips after three consecutive opposite samples.
   // Events are tracked as a pending table drained round-robin.
   always @(posedge clk) begin
      int ch;
      bit nv;
      bit chg;
      bit was_pend;
      bit ld;
      bit oset;
      int g;
      if (rst) begin
         m_y    = '0;
         m_run  = '{default: 0};
         m_slot = 0;
         m_pend = '0;
         m_lvl  = '0;
         m_rr   = NCH - 1;
         m_ev   = 1'b0;
         m_ch   = 0;
         m_el   = 1'b0;
         m_ovf  = 1'b0;
      end else begin
         ch  = m_slot;
         chg = 1'b0;
         nv  = 1'b0;
         if (en) begin
            if (i[ch] != m_y[ch]) begin
               m_run[ch]++;
               if (m_run[ch] == 3) begin
                  m_run[ch] = 0;
                  nv        = i[ch];
                  chg       = 1'b1;
               end
            end else begin
               m_run[ch] = 0;
            end
            m_slot = (m_slot + 1) % NCH;
         end
         if (EVT) begin
            was_pend = m_pend[ch];
            ld = 1'b0;
            g  = 0;
            if (!m_ev || evt_ready) begin
               for (int k = 1; k <= NCH; k++) begin
                  if (!ld && m_pend[(m_rr + k) % NCH]) begin
                     ld = 1'b1;
                     g  = (m_rr + k) % NCH;
                  end
               end
            end
            if (ld) begin
               m_ch    = g;
               m_el    = m_lvl[g];
               m_ev    = 1'b1;
               m_pend[g] = 1'b0;
               m_rr    = g;
            end else if (m_ev && evt_ready) begin
               m_ev = 1'b0;
            end
            oset = chg && was_pend && !(ld && g == ch);
            if (chg) begin
               m_pend[ch] = 1'b1;
               m_lvl[ch]  = nv;
            end
            if (oset) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
         end
         if (chg) m_y[ch] = nv;
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (cmp_on) begin
         check("cmp_y",         32'(y),         32'(m_y));
         check("cmp_slot",      32'(slot),      32'(m_slot));
         check("cmp_evt_valid", 32'(evt_valid), 32'(m_ev));
         check("cmp_evt_ch",    32'(evt_ch),    32'(m_ch));
         check("cmp_evt_lvl",   32'(evt_lvl),   32'(m_el));
         check("cmp_ovf",       32'(ovf),       32'(m_ovf));
      end
   end

   logic [NCH-1:0] tv;
   logic [NCH-1:0] tail [8];

   initial begin
      rst       = 1'b1;
      en        = 1'b0;
      i         = '0;
      evt_ready = 1'b0;
      ovf_clr   = 1'b0;
      step(2);
      cmp_on = 1'b1;
      check("rst_y",         32'(y),         32'h0);
      check("rst_slot",      32'(slot),      32'h0);
      check("rst_evt_valid", 32'(evt_valid), 32'h0);
      check("rst_evt_ch",    32'(evt_ch),    32'h0);
      check("rst_ovf",       32'(ovf),       32'h0);

      // i[2] held high: y[2] rises on edge 11, event on edge 12
      rst = 1'b0;
      en  = 1'b1;
      i   = 4'b0100;
      step(10);
      check("ch2_before", 32'(y), 32'h0);
      step(1);
      check("ch2_rise_y", 32'(y), 32'h4);
      check("ch2_rise_slot", 32'(slot), 32'h3);
      step(1);
      check("ch2_evt_valid", 32'(evt_valid), 32'(EVT));
      check("ch2_evt_ch",    32'(evt_ch),    EVT ? 32'h2 : 32'h0);
      check("ch2_evt_lvl",   32'(evt_lvl),   32'(EVT));

      // accept it, then bring channel 1 up (rise on edge 22)
      i         = 4'b0110;
      evt_ready = 1'b1;
      step(1);
      check("accept_drop", 32'(evt_valid), 32'h0);
      evt_ready = 1'b0;
      step(8);
      check("ch1_before", 32'(y), 32'h4);
      step(1);
      check("ch1_rise", 32'(y), 32'h6);
      step(1);
      check("ch1_evt_ch", 32'(evt_ch), EVT ? 32'h1 : 32'h0);
      evt_ready = 1'b1;
      step(1);
      evt_ready = 1'b0;

      // channel 1: two low samples then high again -> stays high, no event
      i = 4'b0100;
      step(6);
      i = 4'b0110;
      step(4);
      check("e_recover_y",   32'(y),         32'h6);
      check("e_recover_evt", 32'(evt_valid), 32'h0);

      // en low for 5 cycles with i toggling: nothing moves
      en = 1'b0;
      tv = 4'b1001;
      for (int k = 0; k < 5; k++) begin
         i  = tv;
         tv = ~tv;
         step(1);
      end
      check("hold_slot", 32'(slot), 32'h2);
      check("hold_y",    32'(y),    32'h6);

      // channels 0 then 3 rise while the sink is stalled
      en = 1'b1;
      i  = 4'b0111;
      step(2);
      i = 4'b1111;
      step(9);
      check("ch0_rise", 32'(y), 32'h7);
      step(1);
      check("ch0_evt_ch",    32'(evt_ch),    32'h0);
      check("ch0_evt_valid", 32'(evt_valid), 32'(EVT));
      step(4);
      check("ch3_rise",      32'(y),         32'hf);
      check("stall_hold_ch", 32'(evt_ch),    32'h0);
      check("stall_hold_v",  32'(evt_valid), 32'(EVT));
      evt_ready = 1'b1;
      step(1);
      check("ch3_evt_ch", 32'(evt_ch),    EVT ? 32'h3 : 32'h0);
      check("ch3_evt_v",  32'(evt_valid), 32'(EVT));
      step(1);
      check("drain_empty", 32'(evt_valid), 32'h0);
      evt_ready = 1'b0;

      // channel 1 falls, rises and falls again with the event unread -> ovf
      i = 4'b1101;
      step(10);
      check("ch1_fall", 32'(y), 32'hd);
      i = 4'b1111;
      step(12);
      check("ch1_rise2", 32'(y), 32'hf);
      i = 4'b1101;
      step(11);
      check("ovf_before", 32'(ovf), 32'h0);
      step(1);
      check("ovf_set",     32'(ovf),     32'(EVT));
      check("ovf_y",       32'(y),       32'hd);
      check("ovf_evt_ch",  32'(evt_ch),  EVT ? 32'h1 : 32'h0);
      check("ovf_evt_lvl", 32'(evt_lvl), 32'h0);
      ovf_clr = 1'b1;
      step(1);
      ovf_clr = 1'b0;
      check("ovf_clear", 32'(ovf), 32'h0);

      // reset with an event presented
      check("pre_rst_valid", 32'(evt_valid), 32'(EVT));
      rst = 1'b1;
      step(1);
      check("mid_rst_valid", 32'(evt_valid), 32'h0);
      check("mid_rst_y",     32'(y),         32'h0);
      check("mid_rst_slot",  32'(slot),      32'h0);
      rst = 1'b0;

      // directed tail: patterns held long enough to flip some levels
      tail[0] = 4'b0001; tail[1] = 4'b0011; tail[2] = 4'b1010; tail[3] = 4'b1111;
      tail[4] = 4'b0000; tail[5] = 4'b0101; tail[6] = 4'b1100; tail[7] = 4'b0110;
      for (int k = 0; k < 8; k++) begin
         i         = tail[k];
         evt_ready = k[0];
         ovf_clr   = (k == 5);
         step(1);
         ovf_clr   = 1'b0;
         step(9);
      end
      evt_ready = 1'b1;
      step(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
